// File: rtl/display_scan_mux.sv
// Time-multiplexed N-digit 7-segment driver with a blanking guard per slot,
// an internal hex decoder and a debounced page-select button.
module display_scan_mux #(
  parameter int N_DIGITS        = 4,
  parameter int REFRESH_DIV     = 50000,
  parameter int BLANK_CYCLES    = 500,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit AN_ACTIVE_LOW   = 1'b0,
  parameter bit SEG_ACTIVE_LOW  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    btn,
  input  logic [4*N_DIGITS-1:0]   page0_data,
  input  logic [4*N_DIGITS-1:0]   page1_data,
  input  logic [N_DIGITS-1:0]     dig_en,
  output logic [6:0]              seg,
  output logic [N_DIGITS-1:0]     an,
  output logic                    page
);

  localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [SW-1:0] SLOT_LAST = SW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DIG_LAST  = DW'(N_DIGITS - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {ST_START, ST_SCAN} state_t;

  state_t                state_q, state_d;
  logic [1:0]            sync_q;
  logic                  btn_db_q, btn_db_d;
  logic [CW-1:0]         db_cnt_q, db_cnt_d;
  logic                  pend_q, pend_d;
  logic                  page_q, page_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [DW-1:0]         dig_q, dig_d;
  logic [3:0]            nib_q, nib_d;
  logic                  en_q, en_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;

  logic                  btn_s, rise, load;
  logic [4*N_DIGITS-1:0] sel;
  logic [N_DIGITS-1:0]   an_raw;
  logic [6:0]            seg_raw;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b0111111;  4'h1: hex7 = 7'b0000110;
      4'h2: hex7 = 7'b1011011;  4'h3: hex7 = 7'b1001111;
      4'h4: hex7 = 7'b1100110;  4'h5: hex7 = 7'b1101101;
      4'h6: hex7 = 7'b1111101;  4'h7: hex7 = 7'b0000111;
      4'h8: hex7 = 7'b1111111;  4'h9: hex7 = 7'b1101111;
      4'hA: hex7 = 7'b1110111;  4'hB: hex7 = 7'b1111100;
      4'hC: hex7 = 7'b0111001;  4'hD: hex7 = 7'b1011110;
      4'hE: hex7 = 7'b1111001;  default: hex7 = 7'b1110001;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    btn_db_d = btn_db_q;
    db_cnt_d = db_cnt_q;
    page_d   = page_q;
    slot_d   = slot_q;
    dig_d    = dig_q;
    nib_d    = nib_q;
    en_d     = en_q;
    rise     = 1'b0;
    load     = 1'b0;
    sel      = '0;
    btn_s    = sync_q[1];

    if (btn_s == btn_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      btn_db_d = btn_s;
      db_cnt_d = '0;
      rise     = btn_s;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
    pend_d = pend_q | rise;

    // ST_START loads digit 0 so the first slot after reset is a full slot.
    case (state_q)
      ST_START: begin
        state_d = ST_SCAN;
        slot_d  = '0;
        dig_d   = '0;
        load    = 1'b1;
      end
      default: begin
        if (slot_q == SLOT_LAST) begin
          slot_d = '0;
          dig_d  = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
          page_d = page_q ^ pend_q;
          pend_d = rise;
          load   = 1'b1;
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
    endcase

    if (load) begin
      sel   = page_d ? page1_data : page0_data;
      nib_d = sel[4*int'(dig_d) +: 4];
      en_d  = dig_en[dig_d];
    end

    an_raw  = '0;
    seg_raw = '0;
    if (int'(slot_q) >= BLANK_CYCLES && en_q) begin
      an_raw[dig_q] = 1'b1;
      seg_raw       = hex7(nib_q);
    end
    an_d  = an_raw ^ {N_DIGITS{AN_ACTIVE_LOW}};
    seg_d = seg_raw ^ {7{SEG_ACTIVE_LOW}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_START;
      sync_q   <= '0;
      btn_db_q <= 1'b0;
      db_cnt_q <= '0;
      pend_q   <= 1'b0;
      page_q   <= 1'b0;
      slot_q   <= '0;
      dig_q    <= '0;
      nib_q    <= '0;
      en_q     <= 1'b0;
      an_q     <= {N_DIGITS{AN_ACTIVE_LOW}};
      seg_q    <= {7{SEG_ACTIVE_LOW}};
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[0], btn};
      btn_db_q <= btn_db_d;
      db_cnt_q <= db_cnt_d;
      pend_q   <= pend_d;
      page_q   <= page_d;
      slot_q   <= slot_d;
      dig_q    <= dig_d;
      nib_q    <= nib_d;
      en_q     <= en_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign page = page_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Scoreboard bench for display_scan_mux: each slot's expected outputs are
// queued as the slot starts and compared cycle by cycle as the DUT emits them.
module tb_display_scan_mux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn;
  logic [7:0] p0, p1;
  logic [1:0] den;
  logic [6:0] seg;
  logic [1:0] an;
  logic       page;

  int n_chk  = 0;
  int n_pass = 0;
  int sidx   = 0;

  typedef struct {
    int         slot;
    logic [1:0] an;
    logic [6:0] seg;
    logic       pg;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  logic [6:0] SEG_TAB [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  display_scan_mux #(
    .N_DIGITS(2), .REFRESH_DIV(8), .BLANK_CYCLES(2), .DEBOUNCE_CYCLES(4),
    .AN_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn),
    .page0_data(p0), .page1_data(p1), .dig_en(den),
    .seg(seg), .an(an), .page(page)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Outputs lag the slot counter by one cycle: 2 blank, 6 lit, and page
  // already shows the next slot's value on the last observation.
  task automatic exp_slot(input int dig, input logic [3:0] nib, input logic en,
                          input logic pg, input logic pgn);
    exp_t e;
    logic lit;
    for (int j = 0; j < 8; j++) begin
      lit    = (j >= 2) && en;
      e.slot = sidx;
      e.an   = lit ? (2'b01 << dig) : 2'b00;
      e.seg  = lit ? SEG_TAB[nib] : 7'b0000000;
      e.pg   = (j < 7) ? pg : pgn;
      sbq.push_back(e);
    end
    sidx++;
  endtask

  task automatic run(input int dig, input logic [3:0] nib, input logic en,
                     input logic pg, input logic pgn);
    exp_slot(dig, nib, en, pg, pgn);
    repeat (8) @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      chk($sformatf("an s%0d", mon_e.slot), an, mon_e.an);
      chk($sformatf("seg s%0d", mon_e.slot), seg, mon_e.seg);
      chk($sformatf("page s%0d", mon_e.slot), page, mon_e.pg);
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; btn = 1'b0; p0 = 8'h3A; p1 = 8'h00; den = 2'b11;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset an", an, 2'b00);
    chk("reset seg", seg, 7'b0000000);
    chk("reset page", page, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // basic scan
    run(0, 4'hA, 1, 0, 0);
    run(1, 4'h3, 1, 0, 0);
    run(0, 4'hA, 1, 0, 0);
    run(1, 4'h3, 1, 0, 0);

    // short bounce is rejected
    exp_slot(0, 4'hA, 1, 0, 0);
    btn = 1'b1; repeat (3) @(negedge clk);
    btn = 1'b0; repeat (5) @(negedge clk);
    run(1, 4'h3, 1, 0, 0);

    // held press toggles at the slot boundary
    p1 = 8'h05; btn = 1'b1;
    run(0, 4'hA, 1, 0, 1);
    exp_slot(1, 4'h0, 1, 1, 1);
    repeat (2) @(negedge clk);
    btn = 1'b0;
    repeat (6) @(negedge clk);
    run(0, 4'h5, 1, 1, 1);

    // press accepted just after a boundary waits a whole slot
    exp_slot(1, 4'h0, 1, 1, 1);
    repeat (3) @(negedge clk);
    btn = 1'b1;
    repeat (5) @(negedge clk);
    run(0, 4'h5, 1, 1, 0);

    // disabled digit 0
    btn = 1'b0; den = 2'b10;
    run(1, 4'h3, 1, 0, 0);
    run(0, 4'hA, 0, 0, 0);

    // mid-slot data change
    den = 2'b11; p0 = 8'h11;
    run(1, 4'h3, 1, 0, 0);
    exp_slot(0, 4'h1, 1, 0, 0);
    repeat (4) @(negedge clk);
    p0 = 8'hFF;
    repeat (4) @(negedge clk);
    run(1, 4'hF, 1, 0, 0);

    // toggle to page 1, then reset mid-slot
    btn = 1'b1;
    run(0, 4'hF, 1, 0, 1);
    btn = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre-reset page", page, 1'b1);
    chk("pre-reset an", an, 2'b10);
    chk("pre-reset seg", seg, SEG_TAB[0]);
    rst_n = 1'b0; p0 = 8'h3A;
    #1;
    chk("async reset an", an, 2'b00);
    chk("async reset seg", seg, 7'b0000000);
    chk("async reset page", page, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run(0, 4'hA, 1, 0, 0);
    run(1, 4'h3, 1, 0, 0);

    repeat (4) @(negedge clk);
    chk("scoreboard drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
